k423_mem_arbiter: RTL

//  Shares the core's single memory port between instruction fetch (IF) and the data load/store path (LS).

---
 rtl/k423_mem_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/k423_mem_arbiter.sv
// k423_mem_arbiter: shares one memory port between instruction fetch (IF)
// and the load/store path (LS). Outstanding requests are tracked in an
// in-order owner-tag FIFO so each response is routed back to its issuer;
// IF responses squashed by a branch flush are dropped.
// Build option: define K423_ARB_RR_EN for round-robin arbitration
// (default: fixed priority, LS over IF).
module k423_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int OST_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    input  logic                if_req_vld_i,
    output logic                if_req_rdy_o,
    input  logic [ADDR_W-1:0]   if_req_addr_i,
    output logic                if_rsp_vld_o,
    input  logic                ls_req_vld_i,
    output logic                ls_req_rdy_o,
    input  logic [ADDR_W-1:0]   ls_req_addr_i,
    input  logic                ls_req_wen_i,
    input  logic [DATA_W-1:0]   ls_req_wdata_i,
    input  logic [DATA_W/8-1:0] ls_req_wstrb_i,
    output logic                ls_rsp_vld_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                mem_req_vld_o,
    input  logic                mem_req_rdy_i,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic                mem_req_wen_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    output logic [DATA_W/8-1:0] mem_req_wstrb_o,
    input  logic                mem_rsp_vld_i,
    input  logic [DATA_W-1:0]   mem_rsp_rdata_i,
    output logic                arb_err_o
);

    localparam int PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

    arb_state_t           state;
    logic                 hold_own;
    logic [CNT_W-1:0]     count;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OST_DEPTH-1:0] tag_own;
    logic [OST_DEPTH-1:0] tag_disc;
    logic                 idle_own;
    logic                 grant_own;
    logic                 full;
    logic                 hs;
    logic                 pop;
    logic                 head_own;
    logic                 head_disc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OST_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef K423_ARB_RR_EN
    logic rr_ptr;

    // Round-robin: on contention the pointer names the preferred owner
    always_comb begin
        idle_own = ls_req_vld_i;
        if (if_req_vld_i && ls_req_vld_i)
            idle_own = rr_ptr;
    end

    // Hand preference to the loser after every contended handshake
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            rr_ptr <= OWN_LS;
        else if (hs && if_req_vld_i && ls_req_vld_i)
            rr_ptr <= ~grant_own;
    end
`else
    // Fixed priority: LS wins whenever it requests
    assign idle_own = ls_req_vld_i;
`endif

    // A stalled request keeps its owner until memory takes it
    assign grant_own = (state == ARB_HOLD) ? hold_own : idle_own;

    // A pop in the same cycle does not free a slot for a new grant
    assign full          = (count == CNT_W'(OST_DEPTH));
    assign mem_req_vld_o = ~full & (grant_own ? ls_req_vld_i : if_req_vld_i);
    assign hs            = mem_req_vld_o & mem_req_rdy_i;
    assign if_req_rdy_o  = hs & (grant_own == OWN_IF);
    assign ls_req_rdy_o  = hs & (grant_own == OWN_LS);

    // IF never writes, so its write fields are forced to zero
    assign mem_req_addr_o  = grant_own ? ls_req_addr_i : if_req_addr_i;
    assign mem_req_wen_o   = grant_own & ls_req_wen_i;
    assign mem_req_wdata_o = grant_own ? ls_req_wdata_i : '0;
    assign mem_req_wstrb_o = grant_own ? ls_req_wstrb_i : '0;

    // A response with nothing outstanding is an error, not a pop
    assign pop       = mem_rsp_vld_i & (count != '0);
    assign head_own  = tag_own[rd_ptr];
    assign head_disc = tag_disc[rd_ptr];

    assign if_rsp_vld_o = pop & (head_own == OWN_IF) & ~head_disc & ~flush_i;
    assign ls_rsp_vld_o = pop & (head_own == OWN_LS);
    assign rsp_rdata_o  = mem_rsp_rdata_i;

    // Grant FSM: latch the owner when memory stalls a presented request
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ARB_IDLE;
            hold_own <= OWN_LS;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (mem_req_vld_o && !mem_req_rdy_i) begin
                        state    <= ARB_HOLD;
                        hold_own <= idle_own;
                    end
                end
                ARB_HOLD: begin
                    if (mem_req_rdy_i)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Owner-tag FIFO: push on handshake, pop on response, flush marks IF tags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag_own  <= '0;
            tag_disc <= '0;
        end else begin
            if (flush_i) begin
                for (int i = 0; i < OST_DEPTH; i++)
                    if (tag_own[i] == OWN_IF)
                        tag_disc[i] <= 1'b1;
            end
            if (hs) begin
                tag_own[wr_ptr]  <= grant_own;
                tag_disc[wr_ptr] <= (grant_own == OWN_IF) & flush_i;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({hs, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error: response arrived with no request outstanding
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            arb_err_o <= 1'b0;
        else if (mem_rsp_vld_i && (count == '0))
            arb_err_o <= 1'b1;
    end

endmodule
